reg_writeback: RTL and testbench
================================

# reg_writeback

Write-side sequencer for the 16×16 register file. Accepts 16-bit ALU results and 32-bit multiply/divide results, queues them in order, and drives the register file write port (`write_en`, `R0_en`, `write_address`, `write_data`) one entry per cycle. A 32-bit result's high word goes to R0. It also publishes a pending-destination mask for the hazard unit, and it holds all writes while `halt_sys` is asserted.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `halt_sys`  in  1  freeze: no pops, no writes issued
- `alu_valid`  in  1  ALU result present this cycle
- `alu_dest`  in  4  ALU destination register
- `alu_result`  in  16  ALU result
- `alu_stall`  out  1  queue full; pipeline must hold the ALU result
- `md_valid`  in  1  mul/div result offered
- `md_ready`  out  1  mul/div result accepted when `md_valid && md_ready`
- `md_dest`  in  4  mul/div low-word destination
- `md_result`  in  32  {high→R0, low→`md_dest`}
- `write_en`  out  1  to register file
- `R0_en`  out  1  to register file; high word goes to R0
- `write_address`  out  4  to register file
- `write_data`  out  32  to register file; {high, low}
- `pending`  out  16  bit i set while any queued or issuing entry targets register i
- `overflow`  out  1  sticky; ALU push was dropped while full

## Operation
- Entry fields: `{dest[3:0], data[31:0], r0}`.
  - ALU push: `{alu_dest, {16'h0, alu_result}, 0}`.
  - Mul/div push: `{md_dest, md_result, 1}`.
- Push order within one cycle: ALU first, then mul/div.
- `alu_stall = (count == DEPTH)`. Combinational.
- `md_ready = (DEPTH - count) >= 2`. Combinational and independent of `alu_valid`, so a simultaneous ALU push always fits.
- `alu_valid` while full: the entry is dropped, `overflow` is set, and the queue is unchanged.
- Pop occurs when `!halt_sys && count != 0`.
  - The head entry is loaded into the output registers: `write_en=1`, `write_address=dest`, `write_data=data`, `R0_en=r0`.
  - In any other cycle, `write_en` and `R0_en` are registered to 0.
  - `write_address` and `write_data` hold their last values when not loaded.
- Pushes and a pop in the same cycle are legal. `count` updates by pushes − pop.
- Pops use stored entries only; there is no bypass from input to output.
- `pending` is the OR over all valid queue entries and the output stage when `write_en=1`:
  - bit `dest` is set for every entry;
  - bit 0 is additionally set when `r0=1`.
- `md_dest == 0`: forwarded unchanged. The register file resolves the collision in favour of the low word.
- `halt_sys`:
  - pushes continue while space allows;
  - no pop;
  - `write_en` and `R0_en` are registered to 0 in the next cycle;
  - the queue contents are preserved.

## Timing
- Reset: `count=0`, head/tail pointers 0, `write_en=0`, `R0_en=0`, `write_address=0`, `write_data=0`, `overflow=0`.
  - Combinational outputs after reset: `pending=0`, `alu_stall=0`, `md_ready=1`.
  - Reset mid-operation discards all queued entries. No write issues in the cycle after reset.
- Latency, empty queue: push at edge N is stored; it pops at edge N+1; `write_en` is high between N+1 and N+2; the register file captures it at edge N+2.
- Throughput: one write per cycle.
- Burst: a cycle with both ALU and mul/div pushes produces writes on two consecutive cycles, ALU first.
- Pointers wrap modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits wide.
- Halt release: the first pop occurs at the first edge with `halt_sys=0`.

## Structure
- Package `wb_pkg`: `wb_entry_t` packed struct `{dest, data, r0}` and `WB_DEPTH_DEFAULT`.
- Sub-module `wb_fifo`: circular buffer holding `wb_entry_t`.
  - Handles dual push, single pop, and count.
  - Exports the valid entries for the `pending` OR.
- Top level (`reg_writeback`) holds push encoding, `md_ready`/`alu_stall` logic, the output registers, `overflow`, and the `pending` reduction.

## Test plan
- Reset, then ALU push `{dest=3, 16'hBEEF}`:
  - `pending[3]=1` next cycle;
  - `write_en=1`, `write_address=3`, `write_data=32'h0000BEEF`, `R0_en=0` two edges after the push;
  - register 3 reads `16'hBEEF`.
- Mul/div push `{dest=5, 32'h1234_5678}`:
  - `R0_en=1`, `write_data=32'h12345678`;
  - afterwards R0 reads `16'h1234` and R5 reads `16'h5678`;
  - `pending` = `16'h0021` while queued.
- Same-cycle ALU `{2, 16'h0001}` and mul/div `{4, 32'hAAAA_0002}`, queue empty:
  - writes issue to addresses 2 then 4 on consecutive cycles;
  - `md_ready` is low whenever `count >= DEPTH-1`.
- `halt_sys` high for 5 cycles with 3 ALU pushes:
  - `write_en=0` throughout the halt;
  - `count=3` during the halt;
  - after release, 3 consecutive writes issue in push order.
- Fill to DEPTH=4 with `halt_sys` held, then one more `alu_valid`:
  - `alu_stall=1`;
  - the extra entry is dropped;
  - `overflow` latches 1 and stays 1 until `rst`.
- Assert `rst` with 2 entries queued:
  - next cycle `count=0`, `pending=0`, `write_en=0`;
  - no stale writes occur after reset is released.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the register file write-back sequencer.
// Queue entry layout and default queue depth.
package wb_pkg;

  localparam int WB_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
    logic        r0;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of write-back entries.
// Two pushes (a before b) and one pop per cycle.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_a,
  input  wb_entry_t              entry_a,
  input  logic                   push_b,
  input  wb_entry_t              entry_b,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       valid,
  output logic [3:0]             ent_dest [DEPTH],
  output logic [DEPTH-1:0]       ent_r0
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   rp;
  logic [PW-1:0]   wp_b;

  assign wp_b = wp + PW'(push_a);

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_a) mem[wp] <= entry_a;
      if (push_b) mem[wp_b] <= entry_b;
      wp    <= wp + PW'(push_a) + PW'(push_b);
      rp    <= rp + PW'(pop);
      count <= count + CW'(push_a)
             + CW'(push_b) - CW'(pop);
    end
  end

  assign head = mem[rp];

  // Slot g is live when its distance from the head is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    logic [PW-1:0] off;
    assign off         = PW'(g) - rp;
    assign valid[g]    = {1'b0, off} < count;
    assign ent_dest[g] = mem[g].dest;
    assign ent_r0[g]   = mem[g].r0;
  end

endmodule

// File: rtl/reg_writeback.sv
// Write-side sequencer for the 16x16 register file.
// Queues ALU and mul/div results and issues one write per cycle.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt_sys,
  input  logic        alu_valid,
  input  logic [3:0]  alu_dest,
  input  logic [15:0] alu_result,
  output logic        alu_stall,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [3:0]  md_dest,
  input  logic [31:0] md_result,
  output logic        write_en,
  output logic        R0_en,
  output logic [3:0]  write_address,
  output logic [31:0] write_data,
  output logic [15:0] pending,
  output logic        overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    count;
  logic [DEPTH-1:0] valid;
  logic [3:0]       ent_dest [DEPTH];
  logic [DEPTH-1:0] ent_r0;
  wb_entry_t        head;
  wb_entry_t        alu_entry;
  wb_entry_t        md_entry;
  logic             push_a;
  logic             push_b;
  logic             pop;

  assign alu_stall = (count == CW'(DEPTH));
  assign md_ready  = (CW'(DEPTH) - count) >= CW'(2);

  assign push_a = alu_valid && !alu_stall;
  assign push_b = md_valid && md_ready;
  assign pop    = !halt_sys && (count != '0);

  assign alu_entry = '{dest: alu_dest,
                       data: {16'h0, alu_result},
                       r0:   1'b0};
  assign md_entry  = '{dest: md_dest,
                       data: md_result,
                       r0:   1'b1};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_a   (push_a),
    .entry_a  (alu_entry),
    .push_b   (push_b),
    .entry_b  (md_entry),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .valid    (valid),
    .ent_dest (ent_dest),
    .ent_r0   (ent_r0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      write_en      <= 1'b0;
      R0_en         <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
      overflow      <= 1'b0;
    end else begin
      write_en <= pop;
      R0_en    <= pop && head.r0;
      if (pop) begin
        write_address <= head.dest;
        write_data    <= head.data;
      end
      if (alu_valid && alu_stall) overflow <= 1'b1;
    end
  end

  // High word of a mul/div result also marks R0 as pending.
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i]) begin
        pending[ent_dest[i]] = 1'b1;
        if (ent_r0[i]) pending[0] = 1'b1;
      end
    end
    if (write_en) begin
      pending[write_address] = 1'b1;
      if (R0_en) pending[0] = 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: vector table plus
// hand sequences, with a write scoreboard and register file model.
module tb_reg_writeback;

  logic        clk;
  logic        rst;
  logic        halt_sys;
  logic        alu_valid;
  logic [3:0]  alu_dest;
  logic [15:0] alu_result;
  logic        alu_stall;
  logic        md_valid;
  logic        md_ready;
  logic [3:0]  md_dest;
  logic [31:0] md_result;
  logic        write_en;
  logic        R0_en;
  logic [3:0]  write_address;
  logic [31:0] write_data;
  logic [15:0] pending;
  logic        overflow;

  reg_writeback #(.DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .halt_sys      (halt_sys),
    .alu_valid     (alu_valid),
    .alu_dest      (alu_dest),
    .alu_result    (alu_result),
    .alu_stall     (alu_stall),
    .md_valid      (md_valid),
    .md_ready      (md_ready),
    .md_dest       (md_dest),
    .md_result     (md_result),
    .write_en      (write_en),
    .R0_en         (R0_en),
    .write_address (write_address),
    .write_data    (write_data),
    .pending       (pending),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    logic        r0;
  } exp_wr_t;

  typedef struct {
    logic        is_md;
    logic [3:0]  dest;
    logic [31:0] data;
    logic [15:0] exp_pend;
    logic [3:0]  rd_a;
    logic [15:0] rd_v;
    logic [3:0]  rd2_a;
    logic [15:0] rd2_v;
  } vec_t;

  exp_wr_t     sb [$];
  exp_wr_t     mon_e;
  logic [15:0] regs [16];
  int          errors = 0;
  int          checks = 0;

  function automatic void check(string name,
                                logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Scoreboard and register file model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && write_en) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h",
                 write_address, write_data);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 32'(write_address), 32'(mon_e.addr));
        check("wr_data", write_data, mon_e.data);
        check("wr_r0", 32'(R0_en), 32'(mon_e.r0));
      end
      if (R0_en) regs[0] = write_data[31:16];
      regs[write_address] = write_data[15:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    md_valid  = 1'b0;
  endtask

  task automatic set_alu(input logic [3:0] d,
                         input logic [15:0] v);
    alu_valid  = 1'b1;
    alu_dest   = d;
    alu_result = v;
  endtask

  task automatic set_md(input logic [3:0] d,
                        input logic [31:0] v);
    md_valid  = 1'b1;
    md_dest   = d;
    md_result = v;
  endtask

  vec_t    vecs [5];
  exp_wr_t w;

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 16'h0;
    rst = 1'b1; halt_sys = 1'b0;
    alu_valid = 1'b0; alu_dest = '0; alu_result = '0;
    md_valid = 1'b0; md_dest = '0; md_result = '0;

    vecs[0] = '{1'b0, 4'd3,  32'h0000_BEEF, 16'h0008,
                4'd3,  16'hBEEF, 4'd3,  16'hBEEF};
    vecs[1] = '{1'b1, 4'd5,  32'h1234_5678, 16'h0021,
                4'd5,  16'h5678, 4'd0,  16'h1234};
    vecs[2] = '{1'b0, 4'd0,  32'h0000_7777, 16'h0001,
                4'd0,  16'h7777, 4'd0,  16'h7777};
    vecs[3] = '{1'b1, 4'd0,  32'hCAFE_0001, 16'h0001,
                4'd0,  16'h0001, 4'd0,  16'h0001};
    vecs[4] = '{1'b0, 4'd15, 32'h0000_8001, 16'h8000,
                4'd15, 16'h8001, 4'd15, 16'h8001};

    tick(); tick();
    rst = 1'b0;
    check("rst_write_en", 32'(write_en), 0);
    check("rst_r0_en", 32'(R0_en), 0);
    check("rst_addr", 32'(write_address), 0);
    check("rst_data", write_data, 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_alu_stall", 32'(alu_stall), 0);
    check("rst_md_ready", 32'(md_ready), 1);

    // Single pushes from the vector table.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].is_md) set_md(vecs[i].dest, vecs[i].data);
      else set_alu(vecs[i].dest, vecs[i].data[15:0]);
      w.addr = vecs[i].dest;
      w.data = vecs[i].is_md ? vecs[i].data
                             : {16'h0, vecs[i].data[15:0]};
      w.r0   = vecs[i].is_md;
      sb.push_back(w);
      tick();
      idle();
      check("vec_pend_queued", 32'(pending), 32'(vecs[i].exp_pend));
      check("vec_no_bypass", 32'(write_en), 0);
      tick();
      check("vec_latency", 32'(write_en), 1);
      check("vec_pend_issue", 32'(pending), 32'(vecs[i].exp_pend));
      tick();
      check("vec_done", 32'(write_en), 0);
      check("vec_pend_clear", 32'(pending), 0);
      check("vec_reg", 32'(regs[vecs[i].rd_a]), 32'(vecs[i].rd_v));
      check("vec_reg2", 32'(regs[vecs[i].rd2_a]), 32'(vecs[i].rd2_v));
    end

    // Same-cycle ALU and mul/div: ALU issues first.
    set_alu(4'd2, 16'h0001);
    set_md(4'd4, 32'hAAAA_0002);
    sb.push_back('{4'd2, 32'h0000_0001, 1'b0});
    sb.push_back('{4'd4, 32'hAAAA_0002, 1'b1});
    tick();
    idle();
    check("burst_pend", 32'(pending), 32'h0015);
    check("burst_count", 32'(dut.count), 2);
    check("burst_md_ready", 32'(md_ready), 1);
    tick();
    check("burst_w1_en", 32'(write_en), 1);
    check("burst_w1_addr", 32'(write_address), 2);
    tick();
    check("burst_w2_en", 32'(write_en), 1);
    check("burst_w2_addr", 32'(write_address), 4);
    tick();
    check("burst_end", 32'(write_en), 0);

    // Halt for 5 cycles with 3 pushes, then release.
    halt_sys = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        set_alu(4'(6 + i), 16'(16'h11 * (i + 1)));
        sb.push_back('{4'(6 + i), 32'(16'h11 * (i + 1)), 1'b0});
      end else begin
        idle();
      end
      tick();
      check("halt_no_write", 32'(write_en), 0);
      if (i >= 2) check("halt_count", 32'(dut.count), 3);
    end
    idle();
    check("halt_md_ready", 32'(md_ready), 0);
    halt_sys = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("release_write", 32'(write_en), 1);
    end
    tick();
    check("release_done", 32'(write_en), 0);

    // Fill under halt, then overflow a dropped ALU push.
    halt_sys = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_alu(4'(i), 16'(16'h100 + i));
      sb.push_back('{4'(i), 32'(16'h100 + i), 1'b0});
      tick();
      if (i == 3) begin
        check("fill3_md_ready", 32'(md_ready), 0);
        check("fill3_stall", 32'(alu_stall), 0);
      end
    end
    check("full_stall", 32'(alu_stall), 1);
    check("full_md_ready", 32'(md_ready), 0);
    check("full_no_ovf", 32'(overflow), 0);
    set_alu(4'd9, 16'h9999);
    tick();
    idle();
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(dut.count), 4);
    check("ovf_pend", 32'(pending), 32'h001E);
    halt_sys = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("ovf_sticky", 32'(overflow), 1);
    check("drain_count", 32'(dut.count), 0);
    check("drain_reg9", 32'(regs[9]), 0);

    // Reset with 2 entries queued discards them.
    halt_sys = 1'b1;
    set_alu(4'd10, 16'hA0A0);
    tick();
    set_alu(4'd11, 16'hB0B0);
    tick();
    idle();
    check("pre_rst_count", 32'(dut.count), 2);
    rst = 1'b1;
    halt_sys = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_count", 32'(dut.count), 0);
    check("mid_rst_pend", 32'(pending), 0);
    check("mid_rst_we", 32'(write_en), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_no_write", 32'(write_en), 0);
    end
    check("sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
